// File: rtl/worker_cpu_mult_pipe.sv
// Pipelined signed/unsigned DATA_W x DATA_W multiplier with a full-width product.
// Define WORKER_CPU_MULT_OUT_REG_EN to add a third output register stage (latency 3).
module worker_cpu_mult_pipe #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              sign_a,
  input  logic              sign_b,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              out_valid,
  output logic [DATA_W-1:0] result_lo,
  output logic [DATA_W-1:0] result_hi,
  output logic              busy
);

  localparam int HALF_W = DATA_W / 2;
  localparam int PP_W   = DATA_W + 2;
  localparam int PROD_W = 2 * DATA_W;

  // Every half is widened to PP_W so each partial product is exact without width games.
  logic signed [PP_W-1:0] a_lo_x, a_hi_x, b_lo_x, b_hi_x;

  always_comb begin
    a_lo_x = {{(PP_W-HALF_W){1'b0}}, src_a[HALF_W-1:0]};
    b_lo_x = {{(PP_W-HALF_W){1'b0}}, src_b[HALF_W-1:0]};
    a_hi_x = {{(PP_W-HALF_W){sign_a & src_a[DATA_W-1]}}, src_a[DATA_W-1:HALF_W]};
    b_hi_x = {{(PP_W-HALF_W){sign_b & src_b[DATA_W-1]}}, src_b[DATA_W-1:HALF_W]};
  end

  logic signed [PP_W-1:0] p_ll, p_lh, p_hl, p_hh;
  logic                   v1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_ll <= '0;
      p_lh <= '0;
      p_hl <= '0;
      p_hh <= '0;
      v1   <= 1'b0;
    end else begin
      if (en) begin
        p_ll <= a_lo_x * b_lo_x;
        p_lh <= a_lo_x * b_hi_x;
        p_hl <= a_hi_x * b_lo_x;
        p_hh <= a_hi_x * b_hi_x;
      end
      if (flush)   v1 <= 1'b0;
      else if (en) v1 <= in_valid;
    end
  end

  function automatic logic [PROD_W-1:0] sext(input logic [PP_W-1:0] p);
    sext = {{(PROD_W-PP_W){p[PP_W-1]}}, p};
  endfunction

  logic [PROD_W-1:0] sum;

  always_comb begin
    sum = sext(p_ll) + (sext(p_lh) << HALF_W) + (sext(p_hl) << HALF_W)
        + (sext(p_hh) << DATA_W);
  end

  logic [PROD_W-1:0] prod2;
  logic              v2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod2 <= '0;
      v2    <= 1'b0;
    end else begin
      if (en) prod2 <= sum;
      if (flush)   v2 <= 1'b0;
      else if (en) v2 <= v1;
    end
  end

`ifdef WORKER_CPU_MULT_OUT_REG_EN
  logic [PROD_W-1:0] prod3;
  logic              v3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod3 <= '0;
      v3    <= 1'b0;
    end else begin
      if (en) prod3 <= prod2;
      if (flush)   v3 <= 1'b0;
      else if (en) v3 <= v2;
    end
  end

  assign out_valid = v3;
  assign result_lo = prod3[DATA_W-1:0];
  assign result_hi = prod3[PROD_W-1:DATA_W];
  assign busy      = v1 | v2 | v3;
`else
  assign out_valid = v2;
  assign result_lo = prod2[DATA_W-1:0];
  assign result_hi = prod2[PROD_W-1:DATA_W];
  assign busy      = v1 | v2;
`endif

endmodule

// File: tb/tb_worker_cpu_mult_pipe.sv
// Self-checking bench for worker_cpu_mult_pipe: directed cases plus randomized runs
// against an arithmetic reference model, on a 32-bit and a 16-bit instance.
module tb_worker_cpu_mult_pipe;

`ifdef WORKER_CPU_MULT_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        en, flush, in_valid, sign_a, sign_b;
  logic [31:0] src_a, src_b;
  logic        out_valid, busy;
  logic [31:0] result_lo, result_hi;

  logic        en16, flush16, in_valid16, sign_a16, sign_b16;
  logic [15:0] src_a16, src_b16;
  logic        out_valid16, busy16;
  logic [15:0] result_lo16, result_hi16;

  int passed = 0;
  int total  = 0;

  typedef struct {
    bit          v;
    logic [63:0] p;
  } slot_t;

  always #5 clk = ~clk;

  worker_cpu_mult_pipe #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
    .sign_a(sign_a), .sign_b(sign_b), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .result_lo(result_lo), .result_hi(result_hi), .busy(busy)
  );

  worker_cpu_mult_pipe #(.DATA_W(16)) dut16 (
    .clk(clk), .reset(reset), .en(en16), .flush(flush16), .in_valid(in_valid16),
    .sign_a(sign_a16), .sign_b(sign_b16), .src_a(src_a16), .src_b(src_b16),
    .out_valid(out_valid16), .result_lo(result_lo16), .result_hi(result_hi16), .busy(busy16)
  );

  // Exact product: widen each operand according to its mode and multiply.
  function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b,
                                        input logic sa, input logic sb);
    logic signed [65:0] av, bv, p;
    av = {{34{sa & a[31]}}, a};
    bv = {{34{sb & b[31]}}, b};
    p  = av * bv;
    return p[63:0];
  endfunction

  function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                        input logic sa, input logic sb);
    logic signed [33:0] av, bv, p;
    av = {{18{sa & a[15]}}, a};
    bv = {{18{sb & b[15]}}, b};
    p  = av * bv;
    return p[31:0];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input logic v, input logic sa, input logic sb,
                       input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    sign_a   = sa;
    sign_b   = sb;
    src_a    = a;
    src_b    = b;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic sa, input logic sb,
                        output logic early, output logic ov,
                        output logic [31:0] hi, output logic [31:0] lo);
    early = 1'b0;
    drive(1'b1, sa, sb, a, b);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k == 1) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      if (k < LAT) early = early | out_valid;
    end
    ov = out_valid;
    hi = result_hi;
    lo = result_lo;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || result_lo !== 32'h0 || result_hi !== 32'h0)
      $display("[TB] FAIL reset_state: valid=%b busy=%b hi=%h lo=%h, want 0/0/0/0",
               out_valid, busy, result_hi, result_lo);
    else passed++;
    total++;
    if (out_valid16 !== 1'b0 || busy16 !== 1'b0 || result_lo16 !== 16'h0 || result_hi16 !== 16'h0)
      $display("[TB] FAIL reset_state16: valid=%b busy=%b hi=%h lo=%h, want 0/0/0/0",
               out_valid16, busy16, result_hi16, result_lo16);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] a_tab [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b_tab [6] = '{32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFF,
                               32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    logic        sa_tab[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        sb_tab[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [63:0] want  [6] = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFFB,
                               64'hFFFF_FFFF_0000_0001, 64'h4000_0000_0000_0000,
                               64'h4000_0000_0000_0000, 64'hC000_0000_0000_0000};
    logic        early, ov;
    logic [31:0] hi, lo;
    for (int i = 0; i < 6; i++) begin
      run_op(a_tab[i], b_tab[i], sa_tab[i], sb_tab[i], early, ov, hi, lo);
      total++;
      if (early !== 1'b0 || ov !== 1'b1)
        $display("[TB] FAIL directed%0d_latency: early=%b valid=%b, want 0/1", i, early, ov);
      else passed++;
      total++;
      if ({hi, lo} !== want[i])
        $display("[TB] FAIL directed%0d_product: got %h_%h, want %h", i, hi, lo, want[i]);
      else passed++;
    end
  endtask

  task automatic test_stall();
    logic [63:0] got[$];
    logic [63:0] want[3] = '{64'd12, 64'd30, 64'd56};
    logic        snap_v;
    logic [63:0] snap_p;
    for (int c = 0; c < 10; c++) begin
      en = !(c == 2 || c == 3);
      case (c)
        0:       drive(1'b1, 1'b0, 1'b0, 32'd3, 32'd4);
        1:       drive(1'b1, 1'b0, 1'b0, 32'd5, 32'd6);
        2:       drive(1'b1, 1'b0, 1'b0, 32'd11, 32'd11);
        4:       drive(1'b1, 1'b0, 1'b0, 32'd7, 32'd8);
        default: drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      endcase
      @(negedge clk);
      if (en && out_valid) got.push_back({result_hi, result_lo});
      if (c == 1) begin
        snap_v = out_valid;
        snap_p = {result_hi, result_lo};
      end
      if (c == 2 || c == 3) begin
        total++;
        if (out_valid !== snap_v || {result_hi, result_lo} !== snap_p)
          $display("[TB] FAIL stall_frozen_c%0d: valid=%b prod=%h, want %b/%h",
                   c, out_valid, {result_hi, result_lo}, snap_v, snap_p);
        else passed++;
      end
    end
    en = 1'b1;
    total++;
    if (got.size() != 3)
      $display("[TB] FAIL stall_count: got %0d results, want 3", got.size());
    else passed++;
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      total++;
      if (got[i] !== want[i])
        $display("[TB] FAIL stall_result%0d: got %0d, want %0d", i, got[i], want[i]);
      else passed++;
    end
  endtask

  task automatic test_flush();
    logic seen = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'd9, 32'd9);
    @(negedge clk);
    flush = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'd2, 32'd2);
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0)
      $display("[TB] FAIL flush_busy: busy=%b valid=%b, want 0/0", busy, out_valid);
    else passed++;
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    total++;
    if (seen !== 1'b0)
      $display("[TB] FAIL flush_no_output: valid seen=%b, want 0", seen);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic early, ov, seen;
    logic [31:0] hi, lo;
    run_op(32'd3, 32'd3, 1'b0, 1'b0, early, ov, hi, lo);
    drive(1'b1, 1'b0, 1'b0, 32'd2, 32'd2);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #2 reset = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || result_lo !== 32'h0 || result_hi !== 32'h0)
      $display("[TB] FAIL reset_mid: valid=%b busy=%b hi=%h lo=%h, want 0/0/0/0",
               out_valid, busy, result_hi, result_lo);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    total++;
    if (seen !== 1'b0)
      $display("[TB] FAIL reset_no_output: valid seen=%b, want 0", seen);
    else passed++;
  endtask

  // Model: one slot per enabled edge; the output shows the slot LAT enabled edges back,
  // and a flush invalidates everything still in flight.
  task automatic test_random32();
    slot_t       q[$];
    slot_t       s;
    logic [63:0] r;
    bit          exp_v, exp_busy;
    int          n;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 400; c++) begin
      en    = ($urandom_range(0, 9) < 8);
      flush = ($urandom_range(0, 19) == 0);
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 1), $urandom_range(0, 1),
            pick_operand(), pick_operand());
      r = ref32(src_a, src_b, sign_a, sign_b);
      @(negedge clk);
      if (flush) foreach (q[i]) q[i].v = 1'b0;
      if (en) begin
        s.v = in_valid && !flush;
        s.p = r;
        q.push_back(s);
      end
      while (q.size() > LAT) void'(q.pop_front());
      n        = q.size();
      exp_v    = (n == LAT) ? q[0].v : 1'b0;
      exp_busy = 1'b0;
      foreach (q[i]) exp_busy |= q[i].v;
      total++;
      if (out_valid !== exp_v || busy !== exp_busy)
        $display("[TB] FAIL rand32_valid c%0d: valid=%b busy=%b, want %b/%b",
                 c, out_valid, busy, exp_v, exp_busy);
      else passed++;
      if (exp_v) begin
        total++;
        if ({result_hi, result_lo} !== q[0].p)
          $display("[TB] FAIL rand32_product c%0d: got %h, want %h",
                   c, {result_hi, result_lo}, q[0].p);
        else passed++;
      end
    end
    en    = 1'b1;
    flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_w16();
    logic        early = 1'b0;
    logic [31:0] hist[$];
    logic [31:0] want;
    in_valid16 = 1'b1;
    sign_a16   = 1'b0;
    sign_b16   = 1'b0;
    src_a16    = 16'hFFFF;
    src_b16    = 16'hFFFF;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k == 1) in_valid16 = 1'b0;
      if (k < LAT) early = early | out_valid16;
    end
    total++;
    if (early !== 1'b0 || out_valid16 !== 1'b1 || {result_hi16, result_lo16} !== 32'hFFFE_0001)
      $display("[TB] FAIL w16_ffff: early=%b valid=%b prod=%h, want 0/1/fffe0001",
               early, out_valid16, {result_hi16, result_lo16});
    else passed++;
    // Back-to-back random stream; each result must surface exactly LAT edges after issue.
    for (int c = 0; c < 1000 + LAT; c++) begin
      in_valid16 = (c < 1000);
      sign_a16   = $urandom_range(0, 1);
      sign_b16   = $urandom_range(0, 1);
      src_a16    = $urandom;
      src_b16    = $urandom;
      hist.push_back(ref16(src_a16, src_b16, sign_a16, sign_b16));
      @(negedge clk);
      if (c >= LAT - 1 && c < 1000 + LAT - 1) begin
        want = hist[c - LAT + 1];
        total++;
        if (out_valid16 !== 1'b1 || {result_hi16, result_lo16} !== want)
          $display("[TB] FAIL w16_rand c%0d: valid=%b prod=%h, want 1/%h",
                   c, out_valid16, {result_hi16, result_lo16}, want);
        else passed++;
      end
    end
    in_valid16 = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b1; flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    en16 = 1'b1; flush16 = 1'b0; in_valid16 = 1'b0;
    sign_a16 = 1'b0; sign_b16 = 1'b0; src_a16 = '0; src_b16 = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random32();
    test_w16();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
